// File: rtl/mergencam_proc.sv
// Merges per-camera colour histograms into 2*C_NCAMS-1 virtual cams and selects the strongest.
// Latency: 2*C_NCAMS cycles from the completing frame pulse; pulses arriving during the scan are dropped and flagged.
module mergencam_proc #(
    parameter int C_NCAMS   = 3,
    parameter int C_NBINS   = 8,
    parameter int C_NB_HIST = 11,
    parameter int C_NB_PXLS = 14,
    parameter int C_TIMEOUT = 1024,
    parameter int C_HYST    = 64,
    parameter int C_NB_SEL  = $clog2(2*C_NCAMS-1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [C_NCAMS-1:0]                   new_frame_proc_i,
    input  logic [C_NCAMS*C_NB_PXLS-1:0]         colorpxls_i,
    input  logic [C_NCAMS*C_NBINS*C_NB_HIST-1:0] hist_i,
    output logic                                 new_mergeframe_o,
    output logic [C_NB_SEL-1:0]                  cam_sel_o,
    output logic [C_NB_PXLS-1:0]                 colorpxls_o,
    output logic [C_NBINS*C_NB_HIST-1:0]         hist_o,
    output logic                                 partial_o,
    output logic [C_NCAMS-1:0]                   missing_o,
    output logic                                 overrun_o
);

    localparam int NV   = 2*C_NCAMS-1;
    localparam int P    = C_NB_PXLS;
    localparam int HW   = C_NBINS*C_NB_HIST;
    localparam int HALF = (C_NBINS/2)*C_NB_HIST;
    localparam int SUMW = C_NB_HIST + $clog2(C_NBINS) + 1;
    localparam int WW   = (SUMW > P) ? SUMW : P+1;
    localparam int CNTW = $clog2(C_TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EVAL, S_OUT} state_t;

    state_t                  state_q;
    logic [C_NCAMS-1:0]      valid_q;
    logic [C_NCAMS*P-1:0]    cap_pxls_q;
    logic [C_NCAMS*HW-1:0]   cap_hist_q;
    logic [CNTW-1:0]         cnt_q;
    logic                    timeout_q;
    logic [C_NB_SEL-1:0]     idx_q;
    logic [C_NB_SEL-1:0]     best_idx_q;
    logic [P-1:0]            best_tot_q;
    logic [C_NB_SEL-1:0]     prev_sel_q;

    logic                    new_mergeframe_q;
    logic [C_NB_SEL-1:0]     cam_sel_q;
    logic [P-1:0]            colorpxls_q;
    logic [HW-1:0]           hist_q;
    logic                    partial_q;
    logic [C_NCAMS-1:0]      missing_q;
    logic                    overrun_q;

    logic [C_NCAMS-1:0]      valid_d;
    logic                    all_valid_d;
    logic [C_NCAMS*HW-1:0]   rhist_flat;
    logic [NV*P-1:0]         vtot_flat;
    logic [NV*HW-1:0]        vhist_flat;

    assign valid_d     = valid_q | new_frame_proc_i;
    assign all_valid_d = &valid_d;

    // Cams that have not reported contribute zeros everywhere.
    for (genvar gk = 0; gk < C_NCAMS; gk++) begin : g_real
        assign rhist_flat[gk*HW +: HW]     = valid_q[gk] ? cap_hist_q[gk*HW +: HW] : '0;
        assign vhist_flat[(2*gk)*HW +: HW] = rhist_flat[gk*HW +: HW];
        assign vtot_flat[(2*gk)*P +: P]    = valid_q[gk] ? cap_pxls_q[gk*P +: P] : '0;
    end

    for (genvar gk = 0; gk < C_NCAMS-1; gk++) begin : g_mid
        logic [HW-1:0] mhist;
        logic [WW-1:0] sum;
        assign mhist = {rhist_flat[(gk+1)*HW +: HALF], rhist_flat[gk*HW + HALF +: HW-HALF]};
        always_comb begin
            sum = '0;
            for (int b = 0; b < C_NBINS; b++) begin
                sum = sum + WW'(mhist[b*C_NB_HIST +: C_NB_HIST]);
            end
        end
        assign vhist_flat[(2*gk+1)*HW +: HW] = mhist;
        assign vtot_flat[(2*gk+1)*P +: P]    = (sum > WW'(2**P - 1)) ? {P{1'b1}} : sum[P-1:0];
    end

    logic [P-1:0]        cur_tot;
    logic [P-1:0]        prev_tot;
    always_comb begin
        cur_tot  = '0;
        prev_tot = '0;
        for (int v = 0; v < NV; v++) begin
            if (idx_q == C_NB_SEL'(v))      cur_tot  = vtot_flat[v*P +: P];
            if (prev_sel_q == C_NB_SEL'(v)) prev_tot = vtot_flat[v*P +: P];
        end
    end

    logic                cur_wins;
    logic [C_NB_SEL-1:0] fin_idx;
    logic [P-1:0]        fin_tot;
    logic                keep_prev;
    logic [C_NB_SEL-1:0] sel;
    logic [P-1:0]        sel_tot;
    logic [HW-1:0]       sel_hist;
    always_comb begin
        cur_wins  = (idx_q == '0) || (cur_tot > best_tot_q);
        fin_idx   = cur_wins ? idx_q : best_idx_q;
        fin_tot   = cur_wins ? cur_tot : best_tot_q;
        keep_prev = (fin_idx != prev_sel_q) &&
                    ({1'b0, fin_tot} <= ({1'b0, prev_tot} + (P+1)'(C_HYST)));
        sel       = keep_prev ? prev_sel_q : fin_idx;
        sel_tot   = '0;
        sel_hist  = '0;
        for (int v = 0; v < NV; v++) begin
            if (sel == C_NB_SEL'(v)) begin
                sel_tot  = vtot_flat[v*P +: P];
                sel_hist = vhist_flat[v*HW +: HW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            valid_q          <= '0;
            cap_pxls_q       <= '0;
            cap_hist_q       <= '0;
            cnt_q            <= '0;
            timeout_q        <= 1'b0;
            idx_q            <= '0;
            best_idx_q       <= '0;
            best_tot_q       <= '0;
            prev_sel_q       <= C_NB_SEL'(C_NCAMS-1);
            new_mergeframe_q <= 1'b0;
            cam_sel_q        <= C_NB_SEL'(C_NCAMS-1);
            colorpxls_q      <= '0;
            hist_q           <= '0;
            partial_q        <= 1'b0;
            missing_q        <= '0;
            overrun_q        <= 1'b0;
        end else begin
            new_mergeframe_q <= 1'b0;
            overrun_q        <= 1'b0;
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    for (int k = 0; k < C_NCAMS; k++) begin
                        if (new_frame_proc_i[k]) begin
                            cap_pxls_q[k*P +: P]   <= colorpxls_i[k*P +: P];
                            cap_hist_q[k*HW +: HW] <= hist_i[k*HW +: HW];
                        end
                    end
                    valid_q <= valid_d;
                    if (all_valid_d || (state_q == S_COLLECT && cnt_q == CNTW'(C_TIMEOUT-1))) begin
                        state_q   <= S_EVAL;
                        timeout_q <= ~all_valid_d;
                        idx_q     <= '0;
                    end else if (state_q == S_IDLE) begin
                        if (|new_frame_proc_i) begin
                            state_q <= S_COLLECT;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_EVAL: begin
                    overrun_q  <= |new_frame_proc_i;
                    best_idx_q <= fin_idx;
                    best_tot_q <= fin_tot;
                    if (idx_q == C_NB_SEL'(NV-1)) begin
                        state_q          <= S_OUT;
                        prev_sel_q       <= sel;
                        new_mergeframe_q <= 1'b1;
                        cam_sel_q        <= sel;
                        colorpxls_q      <= sel_tot;
                        hist_q           <= sel_hist;
                        partial_q        <= timeout_q;
                        missing_q        <= ~valid_q;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    overrun_q <= |new_frame_proc_i;
                    valid_q   <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign new_mergeframe_o = new_mergeframe_q;
    assign cam_sel_o        = cam_sel_q;
    assign colorpxls_o      = colorpxls_q;
    assign hist_o           = hist_q;
    assign partial_o        = partial_q;
    assign missing_o        = missing_q;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_mergencam_proc.sv
// Bench for mergencam_proc: directed scenarios plus random frame traffic against a timeline reference model.
module tb_mergencam_proc;

    localparam int NC = 3, NB = 8, NH = 11, NP = 14, TO = 100, HY = 64, NV = 5, NS = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NC-1:0]      nfp;
    logic [NC*NP-1:0]   cp_bus;
    logic [NC*NB*NH-1:0] h_bus;
    logic               nmf;
    logic [NS-1:0]      cam_sel;
    logic [NP-1:0]      cp_out;
    logic [NB*NH-1:0]   h_out;
    logic               partial;
    logic [NC-1:0]      missing;
    logic               ovr;

    mergencam_proc #(.C_NCAMS(NC), .C_NBINS(NB), .C_NB_HIST(NH), .C_NB_PXLS(NP),
                     .C_TIMEOUT(TO), .C_HYST(HY)) dut (
        .clk(clk), .rst(rst), .new_frame_proc_i(nfp), .colorpxls_i(cp_bus), .hist_i(h_bus),
        .new_mergeframe_o(nmf), .cam_sel_o(cam_sel), .colorpxls_o(cp_out), .hist_o(h_out),
        .partial_o(partial), .missing_o(missing), .overrun_o(ovr));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stimulus data presented on the buses
    int d_cp[NC];
    int d_hb[NC][NB];

    // reference model state
    int cyc;
    bit m_coll;
    int m_first;
    bit [NC-1:0] m_valid;
    int m_cp[NC];
    int m_hb[NC][NB];
    int m_busy_until, m_ovr_at, m_prev;
    bit pend;
    int pend_at, p_sel, p_tot;
    logic [NB*NH-1:0] p_hist;
    bit p_part;
    bit [NC-1:0] p_miss;
    int e_sel, e_tot;
    logic [NB*NH-1:0] e_hist;
    bit e_part;
    bit [NC-1:0] e_miss;

    task automatic model_reset();
        m_coll = 0; m_valid = '0; m_busy_until = -1; m_ovr_at = -1; m_prev = NC-1;
        pend = 0; e_sel = NC-1; e_tot = 0; e_hist = '0; e_part = 0; e_miss = '0;
    endtask

    task automatic merge(input int c);
        int tot[NV];
        int hb[NV][NB];
        int best, sel, k;
        for (int v = 0; v < NV; v++) begin
            k = v / 2;
            tot[v] = 0;
            if (v % 2 == 0) begin
                for (int b = 0; b < NB; b++) hb[v][b] = m_valid[k] ? m_hb[k][b] : 0;
                tot[v] = m_valid[k] ? m_cp[k] : 0;
            end else begin
                for (int b = 0; b < NB/2; b++) begin
                    hb[v][b]      = m_valid[k]   ? m_hb[k][b+NB/2] : 0;
                    hb[v][b+NB/2] = m_valid[k+1] ? m_hb[k+1][b]    : 0;
                end
                for (int b = 0; b < NB; b++) tot[v] += hb[v][b];
                if (tot[v] > (1 << NP) - 1) tot[v] = (1 << NP) - 1;
            end
        end
        best = 0;
        for (int v = 1; v < NV; v++) if (tot[v] > tot[best]) best = v;
        sel = (best != m_prev && tot[best] <= tot[m_prev] + HY) ? m_prev : best;
        m_prev = sel;
        p_sel = sel;
        p_tot = tot[sel];
        for (int b = 0; b < NB; b++) p_hist[b*NH +: NH] = hb[sel][b][NH-1:0];
        p_part = (m_valid != '1);
        p_miss = ~m_valid;
        pend = 1;
        pend_at = c + 2*NC;
    endtask

    task automatic step(input int c, input logic [NC-1:0] p);
        if (c <= m_busy_until) begin
            if (p != '0) m_ovr_at = c + 1;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (p[k]) begin
                    m_cp[k] = d_cp[k];
                    for (int b = 0; b < NB; b++) m_hb[k][b] = d_hb[k][b];
                    m_valid[k] = 1'b1;
                end
            end
            if (p != '0 && !m_coll) begin
                m_coll = 1; m_first = c;
            end
            if (m_coll && (m_valid == '1 || c == m_first + TO)) begin
                merge(c);
                m_coll = 0;
                m_valid = '0;
                m_busy_until = c + 2*NC;
            end
        end
    endtask

    task automatic cycle(input logic [NC-1:0] p);
        bit exp_nmf;
        exp_nmf = 0;
        if (pend && cyc == pend_at) begin
            e_sel = p_sel; e_tot = p_tot; e_hist = p_hist; e_part = p_part; e_miss = p_miss;
            pend = 0; exp_nmf = 1;
        end
        chk("new_mergeframe", nmf, exp_nmf);
        chk("overrun", ovr, cyc == m_ovr_at);
        chk("cam_sel", cam_sel, e_sel);
        chk("colorpxls", cp_out, e_tot);
        chk("hist", h_out, e_hist);
        chk("partial", partial, e_part);
        chk("missing", missing, e_miss);
        for (int k = 0; k < NC; k++) begin
            cp_bus[k*NP +: NP] = d_cp[k][NP-1:0];
            for (int b = 0; b < NB; b++) h_bus[(k*NB+b)*NH +: NH] = d_hb[k][b][NH-1:0];
        end
        nfp = rst ? '0 : p;
        if (!rst) step(cyc, p);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0);
    endtask

    task automatic set_cam(input int k, input int t, input int lo, input int hi);
        d_cp[k] = t;
        for (int b = 0; b < NB; b++) d_hb[k][b] = (b < NB/2) ? lo : hi;
    endtask

    task automatic rand_data();
        bit big;
        for (int k = 0; k < NC; k++) begin
            big = ($urandom_range(0, 7) == 0);
            d_cp[k] = $urandom_range(0, 3000);
            for (int b = 0; b < NB; b++)
                d_hb[k][b] = big ? $urandom_range(1500, 2047) : $urandom_range(0, 600);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        cycle('0);
        cycle('0);
        rst = 1'b0;
    endtask

    initial begin
        logic [NC-1:0] p, mute;
        cyc = 0;
        nfp = '0; cp_bus = '0; h_bus = '0;
        for (int k = 0; k < NC; k++) set_cam(k, 0, 0, 0);
        do_reset();

        // all cams together, cam1 strongest
        set_cam(0, 100, 12, 12); set_cam(1, 300, 37, 37); set_cam(2, 200, 25, 25);
        cycle(3'b111); idle(8);
        // mid cam 1 wins with combined halves
        set_cam(0, 400, 0, 100); set_cam(1, 400, 100, 0); set_cam(2, 0, 0, 0);
        cycle(3'b111); idle(8);
        // hysteresis: restore prev=2, then challenger just inside and just outside the margin
        set_cam(0, 100, 12, 12); set_cam(1, 300, 37, 37); set_cam(2, 200, 25, 25);
        cycle(3'b111); idle(8);
        set_cam(0, 0, 0, 0); set_cam(1, 300, 0, 0); set_cam(2, 350, 0, 0);
        cycle(3'b111); idle(8);
        set_cam(2, 365, 0, 0);
        cycle(3'b111); idle(8);
        // timeout with cam1 missing
        set_cam(0, 500, 10, 20); set_cam(1, 900, 50, 50); set_cam(2, 700, 30, 40);
        cycle(3'b001); idle(5); cycle(3'b100); idle(TO + 10);
        // staggered arrival plus a dropped pulse during the scan
        cycle(3'b001); idle(4); cycle(3'b010); idle(4); cycle(3'b100); idle(1);
        cycle(3'b001); idle(8);
        // same, but reset lands in the middle of the scan
        cycle(3'b001); idle(4); cycle(3'b010); idle(4); cycle(3'b100); idle(1);
        cycle(3'b001);
        do_reset();
        idle(8);
        set_cam(0, 1200, 5, 5); set_cam(1, 100, 1, 1); set_cam(2, 50, 1, 1);
        cycle(3'b111); idle(8);

        // random traffic, with phases where some cams go silent
        for (int ph = 0; ph < 12; ph++) begin
            mute = ($urandom_range(0, 2) == 0) ? NC'($urandom_range(1, 6)) : '0;
            for (int i = 0; i < 250; i++) begin
                rand_data();
                for (int k = 0; k < NC; k++) p[k] = !mute[k] && ($urandom_range(0, 9) == 0);
                cycle(p);
            end
        end
        idle(TO + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
